uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 35 +++
 rtl/uart_receiver.sv | 216 +++++++++++++++++++++
 tb/tb_uart_receiver.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
//   uart_state_t : receiver FSM states
//   PAR_*        : parity mode encodings on the par input (3 behaves as none)
//   par_expected : parity bit the line must carry for a given data word/mode
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    // Odd mode: total ones count (data + parity) is odd, so bit = XNOR-reduce.
    function automatic logic par_expected(input logic [7:0] data, input logic [1:0] mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus falling-edge detect.
//   i_clk     : receiver clock
//   i_rst_n   : asynchronous active-low reset (all flops reset to idle-high)
//   i_rx      : raw serial line
//   o_rx_s    : synchronized line value
//   o_fall_c  : combinational strobe, synchronized line went 1 -> 0
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall_c
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Metastability filter followed by one history flop for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rx_s   = r_sync;
    assign o_fall_c = r_prev & ~r_sync;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: 7/8 data bits, optional odd/even parity, 1/2 stop bits,
// single-entry output holding register with valid/ack handshake and overrun flag.
//   clk_rx, reset_n        : clock (OVS x bit rate), async active-low reset
//   rx                     : serial line, idle high
//   en                     : receive enable, sampled only while idle
//   par, d_num, s_num      : frame format, latched at the start edge
//   ack                    : consumer acknowledge, clears valid and ovr_err
//   data_out, valid        : received word and its availability
//   par_err/frm_err/ovr_err: status of the word in data_out
//   busy                   : receiver is inside a frame
// Build option: UART_RX_MAJORITY_EN selects a 2-of-3 vote around mid-bit instead of
// a single sample; decision timing is identical in both builds.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned OVS = 16
) (
    input  logic       clk_rx,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       en,
    input  logic [1:0] par,
    input  logic       d_num,
    input  logic       s_num,
    input  logic       ack,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       par_err,
    output logic       frm_err,
    output logic       ovr_err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(OVS);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] CNT_DEC  = CW'(OVS / 2);

    logic        w_rx_s;
    logic        w_fall;
    uart_state_t r_state;
    uart_state_t w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [1:0]  r_par;
    logic        r_d_num;
    logic        r_s_num;
    logic        r_par_acc;
    logic        r_frm_acc;
    logic        r_s1;
    logic        w_bit;
    logic        w_samp;
    logic        w_last_bit;
    logic        w_par_on;
    logic        w_start;
    logic        w_done;
    logic [7:0]  r_data_out;
    logic        r_valid;
    logic        r_par_err;
    logic        r_frm_err;
    logic        r_ovr_err;
    logic        r_busy;

    uart_rx_sync u_sync (
        .i_clk    (clk_rx),
        .i_rst_n  (reset_n),
        .i_rx     (rx),
        .o_rx_s   (w_rx_s),
        .o_fall_c (w_fall)
    );

    // Bit decision happens one count after the centre sample so both builds share timing.
    assign w_samp = (r_state != ST_IDLE) && (r_cnt == CNT_DEC);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] CNT_S0 = CW'(OVS / 2 - 2);
    logic r_s0;

    always_ff @(posedge clk_rx or negedge reset_n) begin
        if (!reset_n) begin
            r_s0 <= 1'b1;
        end else if (r_cnt == CNT_S0) begin
            r_s0 <= w_rx_s;
        end
    end

    assign w_bit = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
`else
    assign w_bit = r_s1;
`endif

    assign w_last_bit = (r_bit_idx == (r_d_num ? 3'd7 : 3'd6));
    assign w_par_on   = (r_par == PAR_ODD) || (r_par == PAR_EVEN);

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall && en) begin
                    w_state_nxt = ST_START;
                    w_start     = 1'b1;
                end
            end
            ST_START: begin
                if (w_samp) w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_samp && w_last_bit) w_state_nxt = w_par_on ? ST_PARITY : ST_STOP1;
            end
            ST_PARITY: begin
                if (w_samp) w_state_nxt = ST_STOP1;
            end
            ST_STOP1: begin
                if (w_samp) begin
                    if (r_s_num) begin
                        w_state_nxt = ST_STOP2;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
                    end
                end
            end
            ST_STOP2: begin
                if (w_samp) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, bit-period counter and centre sample.
    always_ff @(posedge clk_rx or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_s1    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (r_state == ST_IDLE || w_state_nxt == ST_IDLE) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_cnt == CNT_S1) r_s1 <= w_rx_s;
        end
    end

    // Frame datapath: format latch, data assembly, per-frame error accumulation.
    always_ff @(posedge clk_rx or negedge reset_n) begin
        if (!reset_n) begin
            r_par     <= PAR_NONE;
            r_d_num   <= 1'b0;
            r_s_num   <= 1'b0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_par_acc <= 1'b0;
            r_frm_acc <= 1'b0;
        end else if (w_start) begin
            r_par     <= par;
            r_d_num   <= d_num;
            r_s_num   <= s_num;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_par_acc <= 1'b0;
            r_frm_acc <= 1'b0;
        end else if (w_samp) begin
            case (r_state)
                ST_DATA: begin
                    r_shift[r_bit_idx] <= w_bit;
                    r_bit_idx          <= r_bit_idx + 3'd1;
                end
                ST_PARITY: r_par_acc <= (w_bit != par_expected(r_shift, r_par));
                ST_STOP1, ST_STOP2: if (!w_bit) r_frm_acc <= 1'b1;
                default: ;
            endcase
        end
    end

    // Output holding register; a same-cycle ack absorbs what would be an overrun.
    always_ff @(posedge clk_rx or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_ovr_err  <= 1'b0;
        end else if (w_done) begin
            r_data_out <= r_shift;
            r_par_err  <= r_par_acc;
            r_frm_err  <= r_frm_acc | ~w_bit;
            r_valid    <= 1'b1;
            r_ovr_err  <= r_valid & ~ack;
        end else if (ack && r_valid) begin
            r_valid    <= 1'b0;
            r_ovr_err  <= 1'b0;
        end
    end

    assign data_out = r_data_out;
    assign valid    = r_valid;
    assign par_err  = r_par_err;
    assign frm_err  = r_frm_err;
    assign ovr_err  = r_ovr_err;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: expected words go into a scoreboard queue when a
// frame is driven and are popped and compared once the receiver presents the word.
module tb_uart_receiver;

    localparam int OVS = 16;

    logic       clk_rx = 1'b0;
    logic       reset_n;
    logic       rx;
    logic       en;
    logic [1:0] par;
    logic       d_num;
    logic       s_num;
    logic       ack;
    logic [7:0] data_out;
    logic       valid;
    logic       par_err;
    logic       frm_err;
    logic       ovr_err;
    logic       busy;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       oe;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   lat;
    logic seen;

    always #5 clk_rx = ~clk_rx;

    uart_receiver #(.OVS(OVS)) dut (
        .clk_rx   (clk_rx),
        .reset_n  (reset_n),
        .rx       (rx),
        .en       (en),
        .par      (par),
        .d_num    (d_num),
        .s_num    (s_num),
        .ack      (ack),
        .data_out (data_out),
        .valid    (valid),
        .par_err  (par_err),
        .frm_err  (frm_err),
        .ovr_err  (ovr_err),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe, input logic oe);
        exp_t e;
        e.data = d;
        e.pe   = pe;
        e.fe   = fe;
        e.oe   = oe;
        sb.push_back(e);
    endtask

    // Drives one frame bit-by-bit on negedges; records cycles until valid first rises.
    task automatic send_frame(input logic [7:0] data, input logic d8, input logic [1:0] pm,
                              input logic s2, input logic bad_par, input logic stop_val,
                              input logic drop_en);
        logic [11:0] b;
        logic [7:0]  dm;
        int          n;
        int          cyc;
        par   = pm;
        d_num = d8;
        s_num = s2;
        dm    = d8 ? data : {1'b0, data[6:0]};
        b     = '1;
        n     = 0;
        b[n]  = 1'b0;
        n++;
        for (int i = 0; i < (d8 ? 8 : 7); i++) begin
            b[n] = data[i];
            n++;
        end
        if (pm == 2'd1 || pm == 2'd2) begin
            b[n] = ((pm == 2'd1) ? ~^dm : ^dm) ^ bad_par;
            n++;
        end
        b[n] = stop_val;
        n++;
        if (s2) begin
            b[n] = stop_val;
            n++;
        end
        seen = valid;
        lat  = 0;
        cyc  = 0;
        for (int i = 0; i <= n; i++) begin
            rx = (i < n) ? b[i] : 1'b1;
            if (drop_en && i == 1) en = 1'b0;
            repeat (OVS) begin
                @(negedge clk_rx);
                cyc++;
                if (!seen && valid === 1'b1) begin
                    seen = 1'b1;
                    lat  = cyc;
                end
            end
        end
    endtask

    task automatic check_frame(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (valid !== 1'b1 && n < 4 * OVS) begin
            @(negedge clk_rx);
            n++;
        end
        check({tag, "_valid"}, 8'(valid), 8'h01);
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb: observed empty queue expected an entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, data_out, e.data);
            check({tag, "_par_err"}, 8'(par_err), 8'(e.pe));
            check({tag, "_frm_err"}, 8'(frm_err), 8'(e.fe));
            check({tag, "_ovr_err"}, 8'(ovr_err), 8'(e.oe));
        end
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk_rx);
        ack = 1'b1;
        @(negedge clk_rx);
        ack = 1'b0;
        check({tag, "_ack_valid"}, 8'(valid), 8'h00);
        check({tag, "_ack_ovr"}, 8'(ovr_err), 8'h00);
    endtask

    initial begin
        rx      = 1'b1;
        en      = 1'b1;
        par     = 2'd0;
        d_num   = 1'b1;
        s_num   = 1'b0;
        ack     = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk_rx);
        check("rst_data", data_out, 8'h00);
        check("rst_valid", 8'(valid), 8'h00);
        check("rst_errs", 8'({par_err, frm_err, ovr_err}), 8'h00);
        check("rst_busy", 8'(busy), 8'h00);
        reset_n = 1'b1;
        repeat (2 * OVS) @(negedge clk_rx);

        // 8 data bits, even parity, one stop bit; also latency window.
        push_exp(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        check("a5_latency", 8'(seen && lat >= 10 * OVS + OVS / 2 && lat <= 11 * OVS + 4), 8'h01);
        check_frame("a5");
        do_ack("a5");

        // 7 data bits, odd parity with wrong parity bit, two stop bits.
        push_exp(8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_frame("3c");
        do_ack("3c");

        // Stop bit low, then a clean frame with parity mode 3 (none).
        push_exp(8'h5A, 1'b0, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("frm");
        do_ack("frm");
        push_exp(8'h96, 1'b0, 1'b0, 1'b0);
        send_frame(8'h96, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        check_frame("after_frm");
        do_ack("after_frm");

        // Overrun: second word replaces first while valid is still held.
        push_exp(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        check_frame("ovr1");
        push_exp(8'h22, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        check_frame("ovr2");
        do_ack("ovr2");

        // Glitch of OVS/4 cycles: start rejected, receiver returns idle.
        rx = 1'b0;
        repeat (OVS / 4) @(negedge clk_rx);
        rx = 1'b1;
        repeat (2) @(negedge clk_rx);
        check("glitch_busy_hi", 8'(busy), 8'h01);
        repeat (2 * OVS) @(negedge clk_rx);
        check("glitch_busy_lo", 8'(busy), 8'h00);
        check("glitch_valid", 8'(valid), 8'h00);

        // Disabled receiver ignores a frame; dropping en mid-frame does not abort it.
        en = 1'b0;
        send_frame(8'h33, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (OVS) @(negedge clk_rx);
        check("en0_valid", 8'(valid), 8'h00);
        check("en0_busy", 8'(busy), 8'h00);
        en = 1'b1;
        repeat (OVS) @(negedge clk_rx);
        push_exp(8'h44, 1'b0, 1'b0, 1'b0);
        send_frame(8'h44, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        check_frame("en_drop");
        do_ack("en_drop");
        en = 1'b1;

        // Break: one framing-error word, then no restart until the line returns high.
        par   = 2'd0;
        d_num = 1'b1;
        s_num = 1'b0;
        push_exp(8'h00, 1'b0, 1'b1, 1'b0);
        rx = 1'b0;
        repeat (12 * OVS) @(negedge clk_rx);
        check_frame("brk");
        do_ack("brk");
        repeat (4 * OVS) @(negedge clk_rx);
        check("brk_hold_valid", 8'(valid), 8'h00);
        check("brk_hold_busy", 8'(busy), 8'h00);
        rx = 1'b1;
        repeat (2 * OVS) @(negedge clk_rx);
        push_exp(8'hC3, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_frame("after_brk");
        do_ack("after_brk");

        // Reset in the middle of a frame while a word is held.
        push_exp(8'h77, 1'b0, 1'b0, 1'b0);
        send_frame(8'h77, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_frame("pre_rst");
        rx = 1'b0;
        repeat (OVS + OVS / 2) @(negedge clk_rx);
        check("mid_busy", 8'(busy), 8'h01);
        #2;
        reset_n = 1'b0;
        rx      = 1'b1;
        #1;
        check("mrst_data", data_out, 8'h00);
        check("mrst_valid", 8'(valid), 8'h00);
        check("mrst_errs", 8'({par_err, frm_err, ovr_err}), 8'h00);
        check("mrst_busy", 8'(busy), 8'h00);
        repeat (3) @(negedge clk_rx);
        reset_n = 1'b1;
        repeat (2 * OVS) @(negedge clk_rx);
        check("post_rst_busy", 8'(busy), 8'h00);
        check("post_rst_valid", 8'(valid), 8'h00);
        push_exp(8'hE7, 1'b0, 1'b0, 1'b0);
        send_frame(8'hE7, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        check_frame("post_rst");
        do_ack("post_rst");

        check("sb_drained", 8'(sb.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
